// File: rtl/collision_detector.sv
// Pac-Man/ghost overlap detector: registers a hit when both per-axis
// absolute centre distances are within the configured pixel tolerances.
module collision_detector #(
    parameter int unsigned HIT_TOL_X = 0,
    parameter int unsigned HIT_TOL_Y = 0
) (
    input  logic        clka,
    input  logic        rst_n,
    input  logic [10:0] ghost_curr_pos_x,
    input  logic [9:0]  ghost_curr_pos_y,
    input  logic [10:0] pacman_curr_pos_x,
    input  logic [9:0]  pacman_curr_pos_y,
    output logic        pacman_is_dead
);

    logic [10:0] dx;
    logic [9:0]  dy;
    logic        hit_x;
    logic        hit_y;
    logic        hit;

    // Larger minus smaller keeps the difference non-negative, so no wrap-around.
    always_comb begin
        if (ghost_curr_pos_x >= pacman_curr_pos_x)
            dx = ghost_curr_pos_x - pacman_curr_pos_x;
        else
            dx = pacman_curr_pos_x - ghost_curr_pos_x;

        if (ghost_curr_pos_y >= pacman_curr_pos_y)
            dy = ghost_curr_pos_y - pacman_curr_pos_y;
        else
            dy = pacman_curr_pos_y - ghost_curr_pos_y;
    end

    // Compared at 32 bits so tolerances beyond the axis range simply always match.
    assign hit_x = (32'(dx) <= HIT_TOL_X);
    assign hit_y = (32'(dy) <= HIT_TOL_Y);
    assign hit   = hit_x & hit_y;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n)
            pacman_is_dead <= 1'b0;
        else
            pacman_is_dead <= hit;
    end

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench: a default-tolerance and a tolerance-8 detector share
// the same position inputs and are compared against a distance-based model.
module tb_collision_detector;

    logic        clka;
    logic        rst_n;
    logic [10:0] gx;
    logic [9:0]  gy;
    logic [10:0] px;
    logic [9:0]  py;
    logic        dead0;
    logic        dead8;

    int checks = 0;
    int errors = 0;

    collision_detector dut0 (
        .clka              (clka),
        .rst_n             (rst_n),
        .ghost_curr_pos_x  (gx),
        .ghost_curr_pos_y  (gy),
        .pacman_curr_pos_x (px),
        .pacman_curr_pos_y (py),
        .pacman_is_dead    (dead0)
    );

    collision_detector #(.HIT_TOL_X(8), .HIT_TOL_Y(8)) dut8 (
        .clka              (clka),
        .rst_n             (rst_n),
        .ghost_curr_pos_x  (gx),
        .ghost_curr_pos_y  (gy),
        .pacman_curr_pos_x (px),
        .pacman_curr_pos_y (py),
        .pacman_is_dead    (dead8)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Reference: Euclid-free per-axis distance test on plain integers.
    function automatic logic model_hit(input int ax, input int ay, input int bx,
                                       input int by, input int tol);
        int ddx;
        int ddy;
        ddx = (ax > bx) ? ax - bx : bx - ax;
        ddy = (ay > by) ? ay - by : by - ay;
        return (ddx <= tol) && (ddy <= tol);
    endfunction

    // Inputs change away from the rising edge; outputs sampled 1 ns after it.
    task automatic apply(input int agx, input int agy, input int apx, input int apy);
        @(negedge clka);
        gx = 11'(agx);
        gy = 10'(agy);
        px = 11'(apx);
        py = 10'(apy);
        @(posedge clka);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dead0 !== 1'b0 || dead8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: dead0=%b dead8=%b required 0 0", dead0, dead8);
        end
        for (int i = 0; i < 3; i++) begin
            apply(807, 402, 807, 402);
            checks++;
            if (dead0 !== 1'b0 || dead8 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: dead0=%b dead8=%b required 0 0", i, dead0, dead8);
            end else
                $display("reset_hold[%0d] ok", i);
        end
        @(negedge clka);
        rst_n = 1'b1;
        @(posedge clka);
        #1;
        checks++;
        if (dead0 !== 1'b1 || dead8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_overlap: dead0=%b dead8=%b required 1 1", dead0, dead8);
        end else
            $display("reset_release_overlap ok");
    endtask

    task automatic test_separate();
        apply(791, 370, 951, 459);
        checks++;
        if (dead0 !== 1'b0) begin
            errors++;
            $display("FAIL separate_tiles: dead0=%b required 0", dead0);
        end else
            $display("separate_tiles ok");
    endtask

    task automatic test_same_tile();
        apply(807, 402, 807, 402);
        checks++;
        if (dead0 !== 1'b1) begin
            errors++;
            $display("FAIL same_tile_latency: dead0=%b required 1", dead0);
        end else
            $display("same_tile_latency ok");
        for (int i = 0; i < 3; i++) begin
            @(posedge clka);
            #1;
            checks++;
            if (dead0 !== 1'b1) begin
                errors++;
                $display("FAIL same_tile_hold[%0d]: dead0=%b required 1", i, dead0);
            end else
                $display("same_tile_hold[%0d] ok", i);
        end
    endtask

    task automatic test_single_axis();
        apply(807, 402, 807, 418);
        checks++;
        if (dead0 !== 1'b0) begin
            errors++;
            $display("FAIL single_axis_x_match: dead0=%b required 0", dead0);
        end else
            $display("single_axis_x_match ok");
        apply(807, 402, 823, 402);
        checks++;
        if (dead0 !== 1'b0) begin
            errors++;
            $display("FAIL single_axis_y_match: dead0=%b required 0", dead0);
        end else
            $display("single_axis_y_match ok");
    endtask

    task automatic test_tolerance();
        int vec [4][5] = '{
            '{807, 402, 815, 402, 1},
            '{807, 402, 816, 402, 0},
            '{807, 402, 799, 394, 1},
            '{2047, 1023, 0, 0, 0}
        };
        for (int i = 0; i < 4; i++) begin
            apply(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
            checks++;
            if (dead8 !== 1'(vec[i][4])) begin
                errors++;
                $display("FAIL tolerance[%0d]: pac=(%0d,%0d) ghost=(%0d,%0d) dead8=%b required %0d",
                         i, vec[i][2], vec[i][3], vec[i][0], vec[i][1], dead8, vec[i][4]);
            end else
                $display("tolerance[%0d] ok", i);
        end
    endtask

    task automatic test_async_reset();
        apply(807, 402, 807, 402);
        @(posedge clka);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dead0 !== 1'b0 || dead8 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_drop: dead0=%b dead8=%b required 0 0", dead0, dead8);
        end else
            $display("async_reset_drop ok");
        for (int i = 0; i < 2; i++) begin
            @(posedge clka);
            #1;
            checks++;
            if (dead0 !== 1'b0) begin
                errors++;
                $display("FAIL async_reset_hold[%0d]: dead0=%b required 0", i, dead0);
            end
        end
        @(negedge clka);
        rst_n = 1'b1;
        @(posedge clka);
        #1;
        checks++;
        if (dead0 !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_release: dead0=%b required 1", dead0);
        end else
            $display("async_reset_release ok");
    endtask

    task automatic test_overlap_ends();
        apply(807, 402, 807, 402);
        checks++;
        if (dead0 !== 1'b1) begin
            errors++;
            $display("FAIL overlap_start: dead0=%b required 1", dead0);
        end
        apply(791, 370, 951, 459);
        checks++;
        if (dead0 !== 1'b0) begin
            errors++;
            $display("FAIL overlap_end: dead0=%b required 0", dead0);
        end else
            $display("overlap_end ok");
    endtask

    task automatic test_random();
        int agx, agy, apx, apy;
        logic e0, e8;
        for (int i = 0; i < 200; i++) begin
            agx = int'($urandom_range(2047));
            agy = int'($urandom_range(1023));
            if ($urandom_range(1) == 0) begin
                apx = agx + int'($urandom_range(24)) - 12;
                apy = agy + int'($urandom_range(24)) - 12;
                if ($urandom_range(3) == 0) begin
                    apx = agx;
                    apy = agy;
                end
                if (apx < 0) apx = 0;
                if (apx > 2047) apx = 2047;
                if (apy < 0) apy = 0;
                if (apy > 1023) apy = 1023;
            end else begin
                apx = int'($urandom_range(2047));
                apy = int'($urandom_range(1023));
            end
            e0 = model_hit(agx, agy, apx, apy, 0);
            e8 = model_hit(agx, agy, apx, apy, 8);
            apply(agx, agy, apx, apy);
            checks++;
            if (dead0 !== e0 || dead8 !== e8) begin
                errors++;
                $display("FAIL random[%0d]: g=(%0d,%0d) p=(%0d,%0d) dead0=%b dead8=%b required %b %b",
                         i, agx, agy, apx, apy, dead0, dead8, e0, e8);
            end else
                $display("random[%0d] g=(%0d,%0d) p=(%0d,%0d) dead0=%b dead8=%b ok",
                         i, agx, agy, apx, apy, dead0, dead8);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        gx = 11'd807;
        gy = 10'd402;
        px = 11'd807;
        py = 10'd402;
        test_reset();
        test_separate();
        test_same_tile();
        test_single_axis();
        test_tolerance();
        test_async_reset();
        test_overlap_ends();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
